// File: rtl/memory_arbiter_pkg.sv
// Shared constants for the memory arbiter: exception codes and FSM state encodings.
package memory_arbiter_pkg;

    localparam int EXCEPTION_LEN = 4;

    localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK          = 4'd0;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_ENV_BREAK   = 4'd1;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_BUS_TIMEOUT = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_EX = 2'd2,
        ST_FAULT   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_bus_watchdog.sv
// Bus watchdog: counts BUSY cycles without ready and flags the edge on which
// the count would reach TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it.
module memory_arbiter_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic busy,
    input  logic ready,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit EN = (TIMEOUT_CYCLES > 0);

    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;

    assign count_inc = count + CW'(1);

    // Ready on the same edge suppresses expiry so a late completion still wins.
    assign expired = EN && busy && !ready && (count_inc == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (EN && busy && !ready) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the core's single memory port between instruction fetch and
// load/store, one transaction at a time, with a bus-timeout fault state.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no transaction; grant EX over IF when both are eligible
// ST_BUSY_IF | fetch on the bus, waiting for memReady_In
// ST_BUSY_EX | load/store on the bus, waiting for memReady_In
// ST_FAULT   | watchdog expired; bus idle, exception raised until rst
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ifReq_In,
    input  logic [ADDR_WIDTH-1:0]    ifAddr_In,
    output logic [DATA_WIDTH-1:0]    ifData_Out,
    output logic                     ifDone_Out,
    input  logic                     exReq_In,
    input  logic                     exWrite_In,
    input  logic [ADDR_WIDTH-1:0]    exAddr_In,
    input  logic [DATA_WIDTH-1:0]    exWData_In,
    input  logic [DATA_WIDTH/8-1:0]  exStrb_In,
    output logic [DATA_WIDTH-1:0]    exData_Out,
    output logic                     exDone_Out,
    output logic                     memValid_Out,
    output logic                     memWrite_Out,
    output logic [ADDR_WIDTH-1:0]    memAddr_Out,
    output logic [DATA_WIDTH-1:0]    memWData_Out,
    output logic [DATA_WIDTH/8-1:0]  memStrb_Out,
    input  logic                     memReady_In,
    input  logic [DATA_WIDTH-1:0]    memRData_In,
    output logic                     execLockSet_Out,
    output logic [EXCEPTION_LEN-1:0] exception_Out
);

    arb_state_t state;
    logic       if_elig;
    logic       ex_elig;
    logic       grant;
    logic       busy;
    logic       wd_expired;

    // A done pulse still high means that request was just served; do not re-grant it.
    assign if_elig = (state == ST_IDLE) && ifReq_In && !ifDone_Out;
    assign ex_elig = (state == ST_IDLE) && exReq_In && !exDone_Out;
    assign grant   = if_elig || ex_elig;
    assign busy    = (state == ST_BUSY_IF) || (state == ST_BUSY_EX);

    assign execLockSet_Out = (state != ST_IDLE) || grant;

    memory_arbiter_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_bus_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant),
        .busy   (busy),
        .ready  (memReady_In),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            memValid_Out  <= 1'b0;
            memWrite_Out  <= 1'b0;
            memAddr_Out   <= '0;
            memWData_Out  <= '0;
            memStrb_Out   <= '0;
            ifData_Out    <= '0;
            exData_Out    <= '0;
            ifDone_Out    <= 1'b0;
            exDone_Out    <= 1'b0;
            exception_Out <= EXCEP_OK;
        end else begin
            ifDone_Out <= 1'b0;
            exDone_Out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ex_elig) begin
                        state        <= ST_BUSY_EX;
                        memValid_Out <= 1'b1;
                        memWrite_Out <= exWrite_In;
                        memAddr_Out  <= exAddr_In;
                        memWData_Out <= exWData_In;
                        memStrb_Out  <= exWrite_In ? exStrb_In : '1;
                    end else if (if_elig) begin
                        state        <= ST_BUSY_IF;
                        memValid_Out <= 1'b1;
                        memWrite_Out <= 1'b0;
                        memAddr_Out  <= ifAddr_In;
                        memWData_Out <= '0;
                        memStrb_Out  <= '1;
                    end
                end
                ST_BUSY_IF, ST_BUSY_EX: begin
                    if (memReady_In) begin
                        state        <= ST_IDLE;
                        memValid_Out <= 1'b0;
                        if (state == ST_BUSY_IF) begin
                            ifData_Out <= memRData_In;
                            ifDone_Out <= 1'b1;
                        end else begin
                            if (!memWrite_Out) begin
                                exData_Out <= memRData_In;
                            end
                            exDone_Out <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        state         <= ST_FAULT;
                        memValid_Out  <= 1'b0;
                        exception_Out <= EXCEP_BUS_TIMEOUT;
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: fetch, contention, zero-wait, reset
// mid-transaction, ready on the last watchdog cycle and bus timeout.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic                     clk;
    logic                     rst;
    logic                     ifReq_In;
    logic [AW-1:0]            ifAddr_In;
    logic [DW-1:0]            ifData_Out;
    logic                     ifDone_Out;
    logic                     exReq_In;
    logic                     exWrite_In;
    logic [AW-1:0]            exAddr_In;
    logic [DW-1:0]            exWData_In;
    logic [DW/8-1:0]          exStrb_In;
    logic [DW-1:0]            exData_Out;
    logic                     exDone_Out;
    logic                     memValid_Out;
    logic                     memWrite_Out;
    logic [AW-1:0]            memAddr_Out;
    logic [DW-1:0]            memWData_Out;
    logic [DW/8-1:0]          memStrb_Out;
    logic                     memReady_In;
    logic [DW-1:0]            memRData_In;
    logic                     execLockSet_Out;
    logic [EXCEPTION_LEN-1:0] exception_Out;

    int n_assert = 0;
    int n_fail   = 0;

    memory_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ifReq_In       (ifReq_In),
        .ifAddr_In      (ifAddr_In),
        .ifData_Out     (ifData_Out),
        .ifDone_Out     (ifDone_Out),
        .exReq_In       (exReq_In),
        .exWrite_In     (exWrite_In),
        .exAddr_In      (exAddr_In),
        .exWData_In     (exWData_In),
        .exStrb_In      (exStrb_In),
        .exData_Out     (exData_Out),
        .exDone_Out     (exDone_Out),
        .memValid_Out   (memValid_Out),
        .memWrite_Out   (memWrite_Out),
        .memAddr_Out    (memAddr_Out),
        .memWData_Out   (memWData_Out),
        .memStrb_Out    (memStrb_Out),
        .memReady_In    (memReady_In),
        .memRData_In    (memRData_In),
        .execLockSet_Out(execLockSet_Out),
        .exception_Out  (exception_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        ifReq_In    = 1'b0;
        ifAddr_In   = '0;
        exReq_In    = 1'b0;
        exWrite_In  = 1'b0;
        exAddr_In   = '0;
        exWData_In  = '0;
        exStrb_In   = '0;
        memReady_In = 1'b0;
        memRData_In = '0;

        // Reset values
        #12;
        chk("rst_valid", 64'(memValid_Out), 64'd0);
        chk("rst_write", 64'(memWrite_Out), 64'd0);
        chk("rst_addr", 64'(memAddr_Out), 64'd0);
        chk("rst_strb", 64'(memStrb_Out), 64'd0);
        chk("rst_lock", 64'(execLockSet_Out), 64'd0);
        chk("rst_ifdata", 64'(ifData_Out), 64'd0);
        chk("rst_exdata", 64'(exData_Out), 64'd0);
        chk("rst_done", 64'({ifDone_Out, exDone_Out}), 64'd0);
        chk("rst_excep", 64'(exception_Out), 64'(EXCEP_OK));
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // Single fetch, two wait cycles
        ifReq_In  = 1'b1;
        ifAddr_In = 32'h100;
        #1;
        chk("f_lock_req", 64'(execLockSet_Out), 64'd1);
        cyc();
        chk("f_valid", 64'(memValid_Out), 64'd1);
        chk("f_addr", 64'(memAddr_Out), 64'h100);
        chk("f_write", 64'(memWrite_Out), 64'd0);
        chk("f_strb", 64'(memStrb_Out), 64'hF);
        cyc();
        chk("f_wait_lock", 64'(execLockSet_Out), 64'd1);
        chk("f_wait_done", 64'(ifDone_Out), 64'd0);
        cyc();
        memReady_In = 1'b1;
        memRData_In = 32'h0050_0093;
        cyc();
        chk("f_done", 64'(ifDone_Out), 64'd1);
        chk("f_data", 64'(ifData_Out), 64'h0050_0093);
        chk("f_valid_off", 64'(memValid_Out), 64'd0);
        memReady_In = 1'b0;
        ifReq_In    = 1'b0;
        #1;
        chk("f_lock_off", 64'(execLockSet_Out), 64'd0);
        cyc();
        chk("f_done_once", 64'(ifDone_Out), 64'd0);

        // EX load, zero wait, seeds exData_Out
        exReq_In    = 1'b1;
        exWrite_In  = 1'b0;
        exAddr_In   = 32'h300;
        memReady_In = 1'b1;
        memRData_In = 32'h1122_3344;
        cyc();
        chk("ld_valid", 64'(memValid_Out), 64'd1);
        chk("ld_addr", 64'(memAddr_Out), 64'h300);
        chk("ld_strb", 64'(memStrb_Out), 64'hF);
        cyc();
        chk("ld_done", 64'(exDone_Out), 64'd1);
        chk("ld_data", 64'(exData_Out), 64'h1122_3344);
        exReq_In    = 1'b0;
        memReady_In = 1'b0;
        cyc();

        // Contention: EX store first, then IF
        exReq_In    = 1'b1;
        exWrite_In  = 1'b1;
        exAddr_In   = 32'h2000;
        exWData_In  = 32'hDEAD_BEEF;
        exStrb_In   = 4'b0011;
        ifReq_In    = 1'b1;
        ifAddr_In   = 32'h104;
        memRData_In = 32'h5555_5555;
        cyc();
        chk("c_ex_valid", 64'(memValid_Out), 64'd1);
        chk("c_ex_write", 64'(memWrite_Out), 64'd1);
        chk("c_ex_addr", 64'(memAddr_Out), 64'h2000);
        chk("c_ex_wdata", 64'(memWData_Out), 64'hDEAD_BEEF);
        chk("c_ex_strb", 64'(memStrb_Out), 64'h3);
        memReady_In = 1'b1;
        cyc();
        chk("c_ex_done", 64'(exDone_Out), 64'd1);
        chk("c_if_notdone", 64'(ifDone_Out), 64'd0);
        chk("c_ex_valid_off", 64'(memValid_Out), 64'd0);
        chk("c_exdata_kept", 64'(exData_Out), 64'h1122_3344);
        chk("c_lock_pending", 64'(execLockSet_Out), 64'd1);
        exReq_In    = 1'b0;
        memReady_In = 1'b0;
        cyc();
        chk("c_if_valid", 64'(memValid_Out), 64'd1);
        chk("c_if_addr", 64'(memAddr_Out), 64'h104);
        chk("c_if_write", 64'(memWrite_Out), 64'd0);
        chk("c_if_strb", 64'(memStrb_Out), 64'hF);
        memReady_In = 1'b1;
        memRData_In = 32'hAABB_CCDD;
        cyc();
        chk("c_if_done", 64'(ifDone_Out), 64'd1);
        chk("c_if_data", 64'(ifData_Out), 64'hAABB_CCDD);
        chk("c_exdata_final", 64'(exData_Out), 64'h1122_3344);
        ifReq_In    = 1'b0;
        memReady_In = 1'b0;
        cyc();

        // Zero-wait held fetch: done on every third cycle only
        ifReq_In    = 1'b1;
        ifAddr_In   = 32'h200;
        memReady_In = 1'b1;
        memRData_In = 32'h1234_5678;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("zw_done_%0d", k), 64'(ifDone_Out), 64'((k % 3) == 2));
        end
        ifReq_In    = 1'b0;
        memReady_In = 1'b0;
        cyc();

        // Reset asserted between edges while BUSY_EX
        exReq_In   = 1'b1;
        exWrite_In = 1'b1;
        exAddr_In  = 32'h3000;
        exWData_In = 32'h0BAD_F00D;
        exStrb_In  = 4'b1100;
        cyc();
        chk("r_valid_busy", 64'(memValid_Out), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("r_valid_async", 64'(memValid_Out), 64'd0);
        chk("r_addr", 64'(memAddr_Out), 64'd0);
        chk("r_done", 64'({ifDone_Out, exDone_Out}), 64'd0);
        chk("r_ifdata", 64'(ifData_Out), 64'd0);
        chk("r_exdata", 64'(exData_Out), 64'd0);
        chk("r_excep", 64'(exception_Out), 64'(EXCEP_OK));
        exReq_In = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("r_no_done", 64'(exDone_Out), 64'd0);
        chk("r_idle_valid", 64'(memValid_Out), 64'd0);

        // Ready on the fourth (final) watchdog cycle
        exReq_In   = 1'b1;
        exWrite_In = 1'b0;
        exAddr_In  = 32'h400;
        cyc();
        cyc();
        cyc();
        cyc();
        chk("wd_last_valid", 64'(memValid_Out), 64'd1);
        memReady_In = 1'b1;
        memRData_In = 32'hCAFE_F00D;
        cyc();
        chk("wd_last_done", 64'(exDone_Out), 64'd1);
        chk("wd_last_data", 64'(exData_Out), 64'hCAFE_F00D);
        chk("wd_last_excep", 64'(exception_Out), 64'(EXCEP_OK));
        exReq_In    = 1'b0;
        memReady_In = 1'b0;
        cyc();

        // Timeout: four BUSY cycles, then FAULT until reset
        ifReq_In  = 1'b1;
        ifAddr_In = 32'h500;
        cyc();
        chk("to_valid_1", 64'(memValid_Out), 64'd1);
        cyc();
        cyc();
        cyc();
        chk("to_valid_4", 64'(memValid_Out), 64'd1);
        chk("to_excep_4", 64'(exception_Out), 64'(EXCEP_OK));
        cyc();
        chk("to_valid_fault", 64'(memValid_Out), 64'd0);
        chk("to_excep_fault", 64'(exception_Out), 64'(EXCEP_BUS_TIMEOUT));
        chk("to_no_done", 64'(ifDone_Out), 64'd0);
        chk("to_lock", 64'(execLockSet_Out), 64'd1);
        ifReq_In = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("to_hold_excep", 64'(exception_Out), 64'(EXCEP_BUS_TIMEOUT));
        chk("to_hold_valid", 64'(memValid_Out), 64'd0);
        chk("to_hold_lock", 64'(execLockSet_Out), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("to_rst_excep", 64'(exception_Out), 64'(EXCEP_OK));
        chk("to_rst_lock", 64'(execLockSet_Out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
